// File: rtl/bram_rd_arbiter.sv
// bram_rd_arbiter: round-robin sharing of one BRAM read port among NREQ trig/addr/done requesters,
// one read in flight at a time with fixed read latency RD_LAT.
module bram_rd_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 13,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_trig,
  input  logic [NREQ*AW-1:0] i_req_addr,
  output logic [NREQ-1:0]   o_req_done,
  output logic [DW-1:0]     o_req_data,
  output logic              o_bram_en,
  output logic [AW-1:0]     o_bram_addr,
  input  logic [DW-1:0]     i_bram_dout,
  output logic              o_busy,
  output logic [2:0]        o_gnt_id
);
  localparam int GW = $clog2(NREQ);
  typedef enum logic [1:0] {ARB, ISSUE, WAIT, RELEASE} state_t;
  state_t state, state_nx;
  logic [GW-1:0] gnt, last, pick, idx;
  logic [1:0] cnt;
  logic found, cap;
  assign cap      = state == WAIT && cnt == 2'd0;
  assign o_busy   = state != ARB;
  assign o_gnt_id = 3'(gnt);
  // first high trig scanning upward from the slot after the last grant
  always_comb begin
    found = 1'b0;
    pick  = last;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = GW'((int'(last) + i) % NREQ);
      if (!found && i_req_trig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    state_nx = state == ARB   ? (found ? ISSUE : ARB) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (cnt == 2'd0 ? RELEASE : WAIT) :
                                (i_req_trig[gnt] ? RELEASE : ARB);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ARB;
    else       state <= state_nx;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gnt         <= '0;
      last        <= GW'(NREQ - 1);
      cnt         <= 2'd0;
      o_bram_en   <= 1'b0;
      o_bram_addr <= '0;
      o_req_data  <= '0;
      o_req_done  <= '0;
    end else begin
      if (state == ARB && found) begin
        gnt         <= pick;
        last        <= pick;
        o_bram_addr <= i_req_addr[int'(pick)*AW +: AW];
      end
      o_bram_en <= state == ARB && found;
      cnt <= state == ISSUE ? 2'(RD_LAT - 1) : (state == WAIT && cnt != 2'd0) ? cnt - 2'd1 : cnt;
      if (cap) o_req_data <= i_bram_dout;
      o_req_done <= cap ? NREQ'(1) << gnt : '0;
    end
  end
endmodule

// File: tb/tb_bram_rd_arbiter.sv
// tb_bram_rd_arbiter: directed checks of grant order, read timing, release handshake and reset,
// against two instances (RD_LAT=1 and RD_LAT=3) each with its own BRAM model.
module tb_bram_rd_arbiter;
  localparam int NREQ = 4, AW = 13, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0] trig = '0, trig3 = '0, done, done3;
  logic [NREQ*AW-1:0] addr = '0, addr3 = '0;
  logic [DW-1:0] data, data3, dout, dout3;
  logic [AW-1:0] baddr, baddr3;
  logic en, en3, busy, busy3;
  logic [2:0] gnt, gnt3;
  logic [DW-1:0] pipe3 [3];

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    return {19'h0, a} ^ 32'hA5A50000;
  endfunction

  // read data appears only in the valid cycle; other cycles carry changing junk
  always @(posedge clk) begin
    dout     <= en  ? exp_data(baddr)  : 32'hBAD00000 + 32'(cyc);
    pipe3[0] <= en3 ? exp_data(baddr3) : 32'hBAD10000 + 32'(cyc);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign dout3 = pipe3[2];

  bram_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_trig(trig), .i_req_addr(addr),
    .o_req_done(done), .o_req_data(data), .o_bram_en(en), .o_bram_addr(baddr),
    .i_bram_dout(dout), .o_busy(busy), .o_gnt_id(gnt));

  bram_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_req_trig(trig3), .i_req_addr(addr3),
    .o_req_done(done3), .o_req_data(data3), .o_bram_en(en3), .o_bram_addr(baddr3),
    .i_bram_dout(dout3), .o_busy(busy3), .o_gnt_id(gnt3));

  int total = 0, bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    trig = '0;
    repeat (2) tick;
    total += 6;
    if (done !== '0)    begin bad++; $display("FAIL rst_done got=%h exp=0", done); end
    if (data !== '0)    begin bad++; $display("FAIL rst_data got=%h exp=0", data); end
    if (en !== 1'b0)    begin bad++; $display("FAIL rst_en got=%b exp=0", en); end
    if (baddr !== '0)   begin bad++; $display("FAIL rst_addr got=%h exp=0", baddr); end
    if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (gnt !== 3'd0)   begin bad++; $display("FAIL rst_gnt got=%0d exp=0", gnt); end
    rst = 1'b0;
    tick;
    trig = 4'b0010;
    addr[AW +: AW] = 13'h055;
    tick;
    total++;
    if (en !== 1'b1 || baddr !== 13'h055 || gnt !== 3'd1)
      begin bad++; $display("FAIL issue en=%b addr=%h gnt=%0d exp 1/055/1", en, baddr, gnt); end
    tick;
    total++;
    if (busy !== 1'b1 || en !== 1'b0) begin bad++; $display("FAIL wait busy=%b en=%b exp 1/0", busy, en); end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({done, data, en, baddr, busy, gnt} !== '0)
      begin bad++; $display("FAIL async_rst done=%h data=%h en=%b addr=%h busy=%b gnt=%0d exp all 0", done, data, en, baddr, busy, gnt); end
    repeat (3) begin
      tick;
      total++;
      if (done !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rst_hold done=%h busy=%b exp 0/0", done, busy); end
    end
    rst = 1'b0;
    trig = 4'b0001;
    addr = '0;
    addr[0 +: AW] = 13'h010;
    tick;
    total++;
    if (done !== '0 || en !== 1'b1 || baddr !== 13'h010 || gnt !== 3'd0)
      begin bad++; $display("FAIL post_rst_issue done=%h en=%b addr=%h gnt=%0d exp 0/1/010/0", done, en, baddr, gnt); end
    tick;
    total++;
    if (done !== '0) begin bad++; $display("FAIL post_rst_early done=%h exp=0", done); end
    tick;
    total++;
    if (done !== 4'b0001 || data !== 32'hA5A50010)
      begin bad++; $display("FAIL post_rst_done done=%h data=%h exp 1/a5a50010", done, data); end
    tick;
    trig = '0;
    repeat (2) tick;
  endtask

  task automatic test_burst;
    int last_d = -1, n = 0;
    logic seen;
    for (int k = 0; k < 16; k++) begin
      trig = 4'b0001;
      addr[0 +: AW] = 13'h0A0 + 13'(k);
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        tick;
        if (done !== '0) begin
          seen = 1'b1;
          n++;
          total++;
          if (done !== 4'b0001 || data !== exp_data(13'h0A0 + 13'(k)))
            begin bad++; $display("FAIL burst_data k=%0d done=%h data=%h exp 1/%h", k, done, data, exp_data(13'h0A0 + 13'(k))); end
          if (last_d >= 0) begin
            total++;
            if (cyc - last_d != 6) begin bad++; $display("FAIL burst_gap k=%0d got=%0d exp=6", k, cyc - last_d); end
          end
          last_d = cyc;
        end
      end
      if (!seen) begin total++; bad++; $display("FAIL burst_timeout k=%0d got=none exp=done", k); end
      tick;
      trig = '0;
      repeat (2) tick;
    end
    total++;
    if (n != 16) begin bad++; $display("FAIL burst_count got=%0d exp=16", n); end
  endtask

  task automatic test_rr;
    int exp_g = 0;
    logic seen;
    reset_pulse;
    for (int k = 0; k < NREQ; k++) addr[k*AW +: AW] = 13'(k * 257);
    trig = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      seen = 1'b0;
      for (int w = 0; w < 12 && !seen; w++) begin
        tick;
        if (done !== '0) begin
          seen = 1'b1;
          total++;
          if (done !== 4'(1 << exp_g) || gnt !== 3'(exp_g) || data !== exp_data(13'(exp_g * 257)))
            begin bad++; $display("FAIL rr_order n=%0d done=%h gnt=%0d data=%h exp gnt=%0d", n, done, gnt, data, exp_g); end
        end
      end
      if (!seen) begin total++; bad++; $display("FAIL rr_timeout n=%0d got=none exp=done", n); end
      tick;
      trig[exp_g] = 1'b0;
      tick;
      trig[exp_g] = 1'b1;
      exp_g = (exp_g + 1) % NREQ;
    end
    trig = '0;
    reset_pulse;
  endtask

  task automatic test_simul;
    int d = 0;
    logic seen;
    addr = '0;
    addr[0*AW +: AW] = 13'h0AB;
    addr[2*AW +: AW] = 13'h222;
    addr[3*AW +: AW] = 13'h333;
    trig = 4'b0100;
    for (int s = 0; s < 3; s++) begin
      seen = 1'b0;
      for (int w = 0; w < 12 && !seen; w++) begin
        tick;
        if (done !== '0) begin
          seen = 1'b1;
          total++;
          case (s)
            0: if (done !== 4'b0100 || gnt !== 3'd2 || data !== exp_data(13'h222))
                 begin bad++; $display("FAIL simul_first done=%h gnt=%0d data=%h exp 4/2", done, gnt, data); end
            1: if (done !== 4'b1000 || gnt !== 3'd3 || data !== exp_data(13'h333) || cyc - d != 5)
                 begin bad++; $display("FAIL simul_second done=%h gnt=%0d gap=%0d exp 8/3/5", done, gnt, cyc - d); end
            default: if (done !== 4'b0001 || gnt !== 3'd0 || data !== exp_data(13'h0AB) || cyc - d != 5)
                 begin bad++; $display("FAIL simul_third done=%h gnt=%0d gap=%0d exp 1/0/5", done, gnt, cyc - d); end
          endcase
          d = cyc;
        end
      end
      if (!seen) begin total++; bad++; $display("FAIL simul_timeout s=%0d got=none exp=done", s); end
      if (s == 0) trig = 4'b1101;
      tick;
      trig[gnt] = 1'b0;
    end
    repeat (2) tick;
  endtask

  task automatic test_drop;
    int extra = 0;
    addr[1*AW +: AW] = 13'h777;
    trig = 4'b0010;
    repeat (2) tick;
    trig = '0;
    tick;
    total++;
    if (done !== 4'b0010 || data !== exp_data(13'h777))
      begin bad++; $display("FAIL drop_done done=%h data=%h exp 2/%h", done, data, exp_data(13'h777)); end
    tick;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL drop_release busy=%b exp=0", busy); end
    repeat (6) begin
      tick;
      if (en !== 1'b0 || done !== '0) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL drop_repeat got=%0d exp=0", extra); end
  endtask

  task automatic test_lat3;
    int early = 0;
    logic [DW-1:0] held;
    addr3[0 +: AW] = 13'h123;
    trig3 = 4'b0001;
    tick;
    total++;
    if (en3 !== 1'b1 || baddr3 !== 13'h123) begin bad++; $display("FAIL lat3_issue en=%b addr=%h exp 1/123", en3, baddr3); end
    tick;
    total++;
    if (en3 !== 1'b0) begin bad++; $display("FAIL lat3_en_width en=%b exp=0", en3); end
    repeat (2) begin
      if (done3 !== '0) early++;
      tick;
    end
    if (done3 !== '0) early++;
    total++;
    if (early != 0) begin bad++; $display("FAIL lat3_early got=%0d exp=0", early); end
    tick;
    total++;
    if (done3 !== 4'b0001 || data3 !== exp_data(13'h123))
      begin bad++; $display("FAIL lat3_done done=%h data=%h exp 1/%h", done3, data3, exp_data(13'h123)); end
    held = data3;
    tick;
    trig3 = '0;
    repeat (3) tick;
    addr3[2*AW +: AW] = 13'h456;
    trig3 = 4'b0100;
    repeat (4) begin
      tick;
      total++;
      if (data3 !== held) begin bad++; $display("FAIL lat3_hold data=%h exp=%h", data3, held); end
    end
    tick;
    total++;
    if (done3 !== 4'b0100 || data3 !== exp_data(13'h456))
      begin bad++; $display("FAIL lat3_second done=%h data=%h exp 4/%h", done3, data3, exp_data(13'h456)); end
    tick;
    trig3 = '0;
    repeat (2) tick;
  endtask

  initial begin
    test_reset;
    test_burst;
    test_rr;
    test_simul;
    test_drop;
    test_lat3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
